// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush scheduler for the FE/DE/EX/M/WB pipeline.
// Resolves load-use, multi-cycle EX, EX redirect and M-busy hazards.
// Optional feature macro: PIPE_CTRL_PERF_EN (builds saturating perf counters).
module pipe_hazard_ctrl #(
  parameter int unsigned MC_LAT_W = 4
) (
  input  logic                clk,
  input  logic                rst_bar,
  input  logic                de_valid,
  input  logic [2:0]          de_src0_idx,
  input  logic [2:0]          de_src1_idx,
  input  logic [1:0]          de_src_used,
  input  logic                ex_valid,
  input  logic                ex_is_load,
  input  logic [2:0]          ex_dst_idx,
  input  logic                ex_mc_start,
  input  logic [MC_LAT_W-1:0] ex_mc_lat,
  input  logic                ex_redirect,
  input  logic                m_busy,
  output logic                fe_stall,
  output logic                stall_fd,
  output logic                stall_de,
  output logic                stall_em,
  output logic                stall_mw,
  output logic                flush_fd,
  output logic                flush_de,
  output logic                flush_em,
  output logic                flush_mw,
  output logic [15:0]         perf_stall_cnt,
  output logic [15:0]         perf_flush_cnt
);

  localparam int unsigned PERF_W = 16;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MC  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [MC_LAT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                load_use;

  // Load-use: a DE source actually read matches the destination of an EX load.
  assign load_use = ex_valid & ex_is_load & de_valid &
                    ((de_src_used[0] & (de_src0_idx == ex_dst_idx)) |
                     (de_src_used[1] & (de_src1_idx == ex_dst_idx)));

  // FSM state and multi-cycle counter register.
  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      state_q  <= ST_RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Prioritised hazard resolution: next state plus same-cycle stall/flush pins.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    fe_stall = 1'b0;
    stall_fd = 1'b0;
    stall_de = 1'b0;
    stall_em = 1'b0;
    stall_mw = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    flush_mw = 1'b0;
    if (!rst_bar) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
      flush_mw = 1'b1;
      state_d  = ST_RUN;
      mc_cnt_d = '0;
    end else if (m_busy) begin
      // Freeze everything upstream of M and bubble into WB.
      fe_stall = 1'b1;
      stall_fd = 1'b1;
      stall_de = 1'b1;
      stall_em = 1'b1;
      flush_mw = 1'b1;
    end else if (state_q == ST_MC) begin
      fe_stall = 1'b1;
      stall_fd = 1'b1;
      stall_de = 1'b1;
      flush_em = 1'b1;
      if (mc_cnt_q <= MC_LAT_W'(1)) begin
        state_d  = ST_RUN;
        mc_cnt_d = '0;
      end else begin
        mc_cnt_d = mc_cnt_q - MC_LAT_W'(1);
      end
    end else if (ex_valid && ex_redirect) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (ex_valid && ex_mc_start && (ex_mc_lat >= MC_LAT_W'(2))) begin
      // First of N-1 stall cycles; N==2 needs no further MC residency.
      fe_stall = 1'b1;
      stall_fd = 1'b1;
      stall_de = 1'b1;
      flush_em = 1'b1;
      if (ex_mc_lat != MC_LAT_W'(2)) begin
        state_d  = ST_MC;
        mc_cnt_d = ex_mc_lat - MC_LAT_W'(2);
      end
    end else if (load_use) begin
      fe_stall = 1'b1;
      stall_fd = 1'b1;
      flush_de = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic              redirect_taken;
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_flush_q;

  assign redirect_taken = rst_bar & ~m_busy & (state_q == ST_RUN) & ex_valid & ex_redirect;

  // Saturating counters of fetch-stall cycles and taken redirects.
  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fe_stall && (perf_stall_q != {PERF_W{1'b1}})) begin
        perf_stall_q <= perf_stall_q + PERF_W'(1);
      end
      if (redirect_taken && (perf_flush_q != {PERF_W{1'b1}})) begin
        perf_flush_q <= perf_flush_q + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = PERF_W'(0);
  assign perf_flush_cnt = PERF_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_bar;
  logic        de_valid;
  logic [2:0]  de_src0_idx, de_src1_idx;
  logic [1:0]  de_src_used;
  logic        ex_valid, ex_is_load;
  logic [2:0]  ex_dst_idx;
  logic        ex_mc_start;
  logic [3:0]  ex_mc_lat;
  logic        ex_redirect, m_busy;
  logic        fe_stall, stall_fd, stall_de, stall_em, stall_mw;
  logic        flush_fd, flush_de, flush_em, flush_mw;
  logic [15:0] perf_stall_cnt, perf_flush_cnt;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: extra MC cycles still owed, and event tallies.
  int mc_left = 0;
  int m_perf_s = 0;
  int m_perf_f = 0;
  bit started = 0;

  // Observed pin tallies for directed scenarios.
  int n_sfd, n_sde, n_fem, n_fmw;

  pipe_hazard_ctrl #(.MC_LAT_W(4)) dut (
    .clk(clk), .rst_bar(rst_bar), .de_valid(de_valid),
    .de_src0_idx(de_src0_idx), .de_src1_idx(de_src1_idx), .de_src_used(de_src_used),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst_idx(ex_dst_idx),
    .ex_mc_start(ex_mc_start), .ex_mc_lat(ex_mc_lat), .ex_redirect(ex_redirect),
    .m_busy(m_busy), .fe_stall(fe_stall), .stall_fd(stall_fd), .stall_de(stall_de),
    .stall_em(stall_em), .stall_mw(stall_mw), .flush_fd(flush_fd), .flush_de(flush_de),
    .flush_em(flush_em), .flush_mw(flush_mw), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst_bar = 1'b1; de_valid = 1'b0; de_src0_idx = 3'd0; de_src1_idx = 3'd0;
    de_src_used = 2'b00; ex_valid = 1'b0; ex_is_load = 1'b0; ex_dst_idx = 3'd0;
    ex_mc_start = 1'b0; ex_mc_lat = 4'd0; ex_redirect = 1'b0; m_busy = 1'b0;
  endtask

  // One clock: evaluate the model for the current inputs, compare, then advance.
  // Expected vector order: {fe, s_fd, s_de, s_em, s_mw, f_fd, f_de, f_em, f_mw}.
  task automatic cyc();
    logic [8:0] e;
    logic [8:0] o;
    int  nleft;
    bit  red;
    bit  lu;
    #2;
    if (started) begin
      chk("perf_stall", 32'(perf_stall_cnt), 32'(m_perf_s));
      chk("perf_flush", 32'(perf_flush_cnt), 32'(m_perf_f));
    end
    lu = ex_valid && ex_is_load && de_valid &&
         ((de_src_used[0] && de_src0_idx == ex_dst_idx) ||
          (de_src_used[1] && de_src1_idx == ex_dst_idx));
    nleft = mc_left;
    red = 0;
    e = 9'b0;
    if (!rst_bar) begin
      e = 9'b0_0000_1111;
      nleft = 0;
    end else if (m_busy) begin
      e = 9'b1_1110_0001;
    end else if (mc_left > 0) begin
      e = 9'b1_1100_0010;
      nleft = mc_left - 1;
    end else if (ex_valid && ex_redirect) begin
      e = 9'b0_0000_1100;
      red = 1;
    end else if (ex_valid && ex_mc_start && int'(ex_mc_lat) >= 2) begin
      e = 9'b1_1100_0010;
      nleft = int'(ex_mc_lat) - 2;
    end else if (lu) begin
      e = 9'b1_1000_0100;
    end
    o = {fe_stall, stall_fd, stall_de, stall_em, stall_mw,
         flush_fd, flush_de, flush_em, flush_mw};
    chk("pins", 32'(o), 32'(e));
    n_sfd += int'(stall_fd);
    n_sde += int'(stall_de);
    n_fem += int'(flush_em);
    n_fmw += int'(flush_mw);
    @(posedge clk);
    mc_left = nleft;
`ifdef PIPE_CTRL_PERF_EN
    if (!rst_bar) begin
      m_perf_s = 0;
      m_perf_f = 0;
    end else begin
      if (e[8] && m_perf_s < 65535) m_perf_s++;
      if (red && m_perf_f < 65535) m_perf_f++;
    end
`endif
    started = 1;
    #1;
  endtask

  task automatic clr_tally();
    n_sfd = 0; n_sde = 0; n_fem = 0; n_fmw = 0;
  endtask

  // Launch one multi-cycle op of latency n, optionally with an M-busy window.
  task automatic run_mc(input int n, input int busy_at, input int busy_len, input int ncyc);
    clr_tally();
    for (int c = 0; c < ncyc; c++) begin
      idle();
      if (c == 0) begin
        ex_valid = 1'b1; ex_mc_start = 1'b1; ex_mc_lat = 4'(n);
      end
      if (c >= busy_at && c < busy_at + busy_len) m_busy = 1'b1;
      cyc();
    end
  endtask

  initial begin
    idle();
    clr_tally();

    // Reset held two cycles with a redirect pending.
    rst_bar = 1'b0; ex_valid = 1'b1; ex_redirect = 1'b1;
    cyc();
    chk("rst_flush", 32'({flush_fd, flush_de, flush_em, flush_mw}), 32'hF);
    cyc();
    chk("rst_stall", 32'({fe_stall, stall_fd, stall_de, stall_em, stall_mw}), 32'h0);
    idle();
    cyc();

    // Load-use on src0 (index 3), then clear, then same index but src0 unused.
    clr_tally();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst_idx = 3'd3;
    de_valid = 1'b1; de_src0_idx = 3'd3; de_src1_idx = 3'd5; de_src_used = 2'b01;
    cyc();
    idle();
    cyc();
    chk("lu_sfd_cnt", 32'(n_sfd), 32'd1);
    clr_tally();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst_idx = 3'd3;
    de_valid = 1'b1; de_src0_idx = 3'd3; de_src1_idx = 3'd5; de_src_used = 2'b10;
    cyc();
    chk("lu_unused_cnt", 32'(n_sfd), 32'd0);
    // Index 0 is an ordinary register.
    clr_tally();
    ex_dst_idx = 3'd0; de_src1_idx = 3'd0;
    cyc();
    chk("lu_idx0_cnt", 32'(n_sfd), 32'd1);

    // Multi-cycle latencies.
    run_mc(4, 99, 0, 6);
    chk("mc4_sfd", 32'(n_sfd), 32'd3);
    chk("mc4_fem", 32'(n_fem), 32'd3);
    run_mc(2, 99, 0, 4);
    chk("mc2_sfd", 32'(n_sfd), 32'd1);
    run_mc(1, 99, 0, 3);
    chk("mc1_sfd", 32'(n_sfd), 32'd0);
    run_mc(5, 2, 2, 9);
    chk("mc5b_sfd", 32'(n_sfd), 32'd6);
    chk("mc5b_fmw", 32'(n_fmw), 32'd2);

    // Redirect beats a load-use match and an N=3 multi-cycle start.
    clr_tally();
    idle();
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_is_load = 1'b1; ex_dst_idx = 3'd2;
    de_valid = 1'b1; de_src0_idx = 3'd2; de_src_used = 2'b01;
    ex_mc_start = 1'b1; ex_mc_lat = 4'd3;
    cyc();
    chk("redir_flush", 32'({flush_fd, flush_de}), 32'h3);
    idle();
    cyc();
    chk("redir_sfd", 32'(n_sfd), 32'd0);

    // Reset in the middle of an MC sequence.
    idle();
    ex_valid = 1'b1; ex_mc_start = 1'b1; ex_mc_lat = 4'd9;
    cyc();
    idle();
    cyc();
    rst_bar = 1'b0;
    cyc();
    idle();
    clr_tally();
    cyc();
    chk("rst_mid_mc", 32'(n_sfd), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      idle();
      rst_bar     = ($urandom_range(0, 99) != 0);
      m_busy      = ($urandom_range(0, 7) == 0);
      de_valid    = 1'($urandom);
      de_src0_idx = 3'($urandom_range(0, 3));
      de_src1_idx = 3'($urandom_range(0, 3));
      de_src_used = 2'($urandom);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_is_load  = 1'($urandom);
      ex_dst_idx  = 3'($urandom_range(0, 3));
      ex_mc_start = ($urandom_range(0, 5) == 0);
      ex_mc_lat   = 4'($urandom);
      ex_redirect = ($urandom_range(0, 7) == 0);
      cyc();
    end

`ifdef PIPE_CTRL_PERF_EN
    idle();
    rst_bar = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle();
      ex_valid = 1'b1; ex_redirect = 1'b1;
      cyc();
    end
    idle();
    cyc();
    chk("perf_flush3", 32'(perf_flush_cnt), 32'd3);
    idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst_idx = 3'd1;
    de_valid = 1'b1; de_src0_idx = 3'd1; de_src_used = 2'b01;
    for (int i = 0; i < 70000; i++) cyc();
    chk("perf_sat", 32'(perf_stall_cnt), 32'hFFFF);
`else
    idle();
    ex_valid = 1'b1; ex_redirect = 1'b1;
    cyc();
    idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst_idx = 3'd1;
    de_valid = 1'b1; de_src0_idx = 3'd1; de_src_used = 2'b01;
    cyc();
    chk("perf_off_s", 32'(perf_stall_cnt), 32'h0);
    chk("perf_off_f", 32'(perf_flush_cnt), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
